// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and state encoding for the stream_mux_rr slice.
// Round-robin arbitration is built only when RR_MODE_EN is defined.
package stream_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;
endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N-to-1 stream handshake: per-channel inputs, select/mode and the output stream.
interface stream_mux_rr_if #(
   parameter int N_CH  = 7,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N_CH)
) ();
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [SEL_W-1:0]      sel;
   logic                  mode;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  in_data, in_valid, sel, mode, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
      output in_data, in_valid, sel, mode, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/stream_mux_rr_rr_pick.sv
// Rotating-priority picker: first requester after 'last', wrapping; purely combinational.
module rr_pick #(
   parameter int N_CH  = 7,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);
   logic [SEL_W-1:0] k;

   // Walk from the farthest candidate to the nearest so the nearest requester wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      k       = '0;
      for (int i = N_CH; i >= 1; i--) begin
         k = SEL_W'((int'(last) + i) % N_CH);
         if (req[k]) begin
            gnt_idx = k;
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with a 1-deep registered output; fixed select or
// round-robin (RR_MODE_EN) channel choice.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int N_CH  = 7,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N_CH)
) (
   input logic            clk,
   input logic            reset,
   stream_mux_rr_if.slave bus
);
   logic [N_CH-1:0][WIDTH-1:0] in_data_w;
   logic [N_CH-1:0]            in_ready_w;
   out_state_e                 state_q, state_d;
   logic [WIDTH-1:0]           out_data_q, out_data_d;
   logic [SEL_W-1:0]           out_ch_q, out_ch_d;
   logic [SEL_W-1:0]           fix_idx, gnt_idx;
   logic                       gnt_vld, load, xfer;

   assign in_data_w = bus.in_data;
   assign load      = (state_q == ST_EMPTY) || bus.out_ready;
   // Out-of-range selects fall back to channel 0.
   assign fix_idx   = ({1'b0, bus.sel} < (SEL_W+1)'(N_CH)) ? bus.sel : '0;

`ifdef RR_MODE_EN
   logic [SEL_W-1:0] last_q, rr_idx;
   logic             rr_any, rr_on;

   rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
      .req     (bus.in_valid),
      .last    (last_q),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   assign rr_on   = (bus.mode == MODE_RR);
   assign gnt_idx = rr_on ? rr_idx : fix_idx;
   assign gnt_vld = rr_on ? rr_any : bus.in_valid[fix_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              last_q <= SEL_W'(N_CH-1);
      else if (xfer && rr_on) last_q <= gnt_idx;
   end
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
   assign gnt_idx     = fix_idx;
   assign gnt_vld     = bus.in_valid[fix_idx];
`endif

   assign xfer = load && gnt_vld && !reset;

   always_comb begin
      in_ready_w = '0;
      if (xfer) in_ready_w[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      if (xfer) begin
         state_d    = ST_FULL;
         out_data_d = in_data_w[gnt_idx];
         out_ch_d   = gnt_idx;
      end else if (load) begin
         state_d    = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         out_ch_q   <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = (state_q == ST_FULL);
endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr against a cycle-level transaction model.
module tb_stream_mux_rr;
   localparam int N_CH  = 7;
   localparam int WIDTH = 8;
   localparam int SEL_W = $clog2(N_CH);
`ifdef RR_MODE_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N_CH-1:0][WIDTH-1:0] t_data  = '0;
   logic [N_CH-1:0]            t_valid = '0;
   logic [SEL_W-1:0]           t_sel   = '0;
   logic                       t_mode  = 1'b0;
   logic                       t_ordy  = 1'b0;

   stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
   assign bus.in_data   = t_data;
   assign bus.in_valid  = t_valid;
   assign bus.sel       = t_sel;
   assign bus.mode      = t_mode;
   assign bus.out_ready = t_ordy;

   stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   bit              m_valid;
   logic [WIDTH-1:0] m_data;
   int              m_ch;
   int              m_last;
   logic [N_CH-1:0] exp_rdy, act_rdy;

   function automatic void model_reset();
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N_CH - 1;
   endfunction

   // Channel that the rules grant this cycle, or -1 for none.
   function automatic int model_grant();
      int order[$];
      int g;
      if (RR_EN && t_mode) begin
         for (int k = m_last + 1; k < N_CH; k++) order.push_back(k);
         for (int k = 0; k <= m_last; k++) order.push_back(k);
         foreach (order[i]) if (t_valid[order[i]]) return order[i];
         return -1;
      end
      g = (int'(t_sel) >= N_CH) ? 0 : int'(t_sel);
      return t_valid[g] ? g : -1;
   endfunction

   // One clock: sample in_ready, advance the model, land at posedge+1.
   task automatic cyc();
      int g;
      #1;
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0 && (!m_valid || t_ordy)) exp_rdy[g] = 1'b1;
      act_rdy = bus.in_ready;
      if (exp_rdy != '0) begin
         m_valid = 1'b1; m_data = t_data[g]; m_ch = g;
         if (RR_EN && t_mode) m_last = g;
      end else if (!m_valid || t_ordy) begin
         m_valid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic rand_data();
      for (int i = 0; i < N_CH; i++) t_data[i] = WIDTH'($urandom);
   endtask

   task automatic test_reset();
      t_valid = '1; t_ordy = 1'b0;
      #3;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid act=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset out_data act=%h exp=00", bus.out_data); end
      n_checks++; if (bus.out_ch !== '0) begin n_fail++; $display("FAIL reset out_ch act=%0d exp=0", bus.out_ch); end
      n_checks++; if (bus.in_ready !== '0) begin n_fail++; $display("FAIL reset in_ready act=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      t_valid = '0;
   endtask

   task automatic test_fixed();
      t_mode = 1'b0; t_sel = 3'd3; t_valid = 7'h08; t_data[3] = 8'hA5; t_ordy = 1'b1;
      cyc();
      n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL fixed in_ready act=%b exp=%b", act_rdy, exp_rdy); end
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL fixed out_valid act=%b exp=%b", bus.out_valid, m_valid); end
      n_checks++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL fixed out_data act=%h exp=%h", bus.out_data, m_data); end
      n_checks++; if (int'(bus.out_ch) != m_ch) begin n_fail++; $display("FAIL fixed out_ch act=%0d exp=%0d", bus.out_ch, m_ch); end
   endtask

   task automatic test_fixed_oor();
      t_mode = 1'b0; t_sel = 3'd7; t_valid = 7'h01; t_data[0] = 8'h11; t_ordy = 1'b1;
      cyc();
      n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL oor in_ready act=%b exp=%b", act_rdy, exp_rdy); end
      n_checks++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL oor out_data act=%h exp=%h", bus.out_data, m_data); end
      n_checks++; if (int'(bus.out_ch) != m_ch) begin n_fail++; $display("FAIL oor out_ch act=%0d exp=%0d", bus.out_ch, m_ch); end
   endtask

   task automatic test_backpressure();
      t_mode = 1'b0; t_sel = SEL_W'($urandom_range(N_CH-1)); t_valid = '1; t_ordy = 1'b1;
      rand_data(); cyc();
      t_ordy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         rand_data(); cyc();
         n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL bp_hold in_ready act=%b exp=%b", act_rdy, exp_rdy); end
         n_checks++; if (bus.out_data !== m_data || bus.out_valid !== m_valid) begin n_fail++; $display("FAIL bp_hold out act=%h/%b exp=%h/%b", bus.out_data, bus.out_valid, m_data, m_valid); end
      end
      t_ordy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         rand_data(); cyc();
         n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL bp_rel in_ready act=%b exp=%b", act_rdy, exp_rdy); end
         n_checks++; if (bus.out_data !== m_data || bus.out_valid !== m_valid) begin n_fail++; $display("FAIL bp_rel out act=%h/%b exp=%h/%b", bus.out_data, bus.out_valid, m_data, m_valid); end
      end
   endtask

   task automatic test_rr_all();
      reset_dut();
      t_mode = 1'b1; t_sel = '0; t_valid = '1; t_ordy = 1'b1;
      for (int c = 0; c < 14; c++) begin
         rand_data(); cyc();
         n_checks++; if (int'(bus.out_ch) != m_ch || bus.out_data !== m_data) begin n_fail++; $display("FAIL rr_all c%0d out act=%0d/%h exp=%0d/%h", c, bus.out_ch, bus.out_data, m_ch, m_data); end
      end
   endtask

   task automatic test_rr_pair();
      t_mode = 1'b1; t_ordy = 1'b1;
      for (int c = 0; c < 7; c++) begin
         t_valid = (c < 4) ? 7'b1000010 : 7'b0000010;
         rand_data(); cyc();
         n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_pair in_ready act=%b exp=%b", act_rdy, exp_rdy); end
         n_checks++; if (int'(bus.out_ch) != m_ch || bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rr_pair c%0d out act=%0d/%b exp=%0d/%b", c, bus.out_ch, bus.out_valid, m_ch, m_valid); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         t_mode  = 1'($urandom);
         t_sel   = SEL_W'($urandom);
         t_valid = N_CH'($urandom) & N_CH'($urandom);
         t_ordy  = ($urandom_range(3) != 0);
         rand_data(); cyc();
         n_checks++; if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL random c%0d in_ready act=%b exp=%b", c, act_rdy, exp_rdy); end
         n_checks++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || int'(bus.out_ch) != m_ch) begin
            n_fail++; $display("FAIL random c%0d out act=%b/%h/%0d exp=%b/%h/%0d", c, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
         end
      end
   endtask

   task automatic test_reset_mid();
      t_mode = 1'b1; t_valid = '1; t_ordy = 1'b1;
      rand_data(); cyc();
      t_ordy = 1'b0;
      rand_data(); cyc();
      #2 reset = 1'b1;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin n_fail++; $display("FAIL reset_mid async act=%b/%h exp=0/00", bus.out_valid, bus.out_data); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      t_ordy = 1'b1;
      rand_data(); cyc();
      n_checks++; if (int'(bus.out_ch) != m_ch || bus.out_data !== m_data || bus.out_valid !== m_valid) begin
         n_fail++; $display("FAIL reset_mid first act=%0d/%h exp=%0d/%h", bus.out_ch, bus.out_data, m_ch, m_data);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fixed();
      test_fixed_oor();
      test_backpressure();
      test_rr_all();
      test_rr_pair();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
